rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the write-data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register-address width.
REQ-003 Parameter LOCK_MAX, default 15, SHALL set the lock-stall cycles allowed before forced release.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 req0_valid, req1_valid  in  1 each  SHALL flag a write request from the ALU writeback (0) or the multi-cycle unit (1).
REQ-007 req0_addr, req1_addr  in  ADDR_W each  SHALL carry the destination register.
REQ-008 req0_data, req1_data  in  DATA_W each  SHALL carry the write data.
REQ-009 req0_lock, req1_lock  in  1 each  SHALL request that the grant be held for the next beat of an atomic pair.
REQ-010 req0_ready, req1_ready  out  1 each  SHALL be the combinational grant; a beat is accepted when valid and ready are both high.
REQ-011 wr_en  out  1  SHALL be the register-file write enable.
REQ-012 wr_sel  out  1  SHALL be the write-port mux select: 0 for requester 0, 1 for requester 1.
REQ-013 wr_addr  out  ADDR_W  SHALL be the registered write address.
REQ-014 wr_data  out  DATA_W  SHALL be the registered write data.
REQ-015 lock_err  out  1  SHALL pulse high for one cycle on a forced lock release.

Function
REQ-016 FSM states SHALL be IDLE, LOCK0 and LOCK1.
REQ-017 In IDLE with exactly one valid request, that requester SHALL be granted.
REQ-018 In IDLE with both requests valid, the requester opposite to last_grant SHALL be granted (round-robin).
REQ-019 last_grant SHALL update to the index of each accepted beat.
REQ-020 At most one ready SHALL be high in any cycle; ready SHALL never be high without its valid.
REQ-021 An accepted beat with lock_i=1 SHALL move the FSM to LOCK_i.
REQ-022 In LOCK_i, only requester i SHALL be grantable; the other requester's ready SHALL be 0 even if requester i is idle.
REQ-023 In LOCK_i, an accepted beat with lock_i=0 SHALL return the FSM to IDLE; with lock_i=1 it SHALL stay in LOCK_i.
REQ-024 A stall counter SHALL count LOCK_i cycles with no accepted beat and SHALL clear on every accepted beat or state change.
REQ-025 When the stall counter reaches LOCK_MAX, the FSM SHALL go to IDLE, lock_err SHALL pulse for one cycle, and last_grant SHALL be set to i.
REQ-026 Latency SHALL be 1 cycle: wr_* in cycle N+1 SHALL reflect the beat accepted in cycle N.
REQ-027 wr_en SHALL be 1 only if a beat was accepted and its address is nonzero; a write to register 0 SHALL be accepted but suppressed.
REQ-028 wr_sel, wr_addr and wr_data SHALL hold their previous values in cycles with no accepted beat.

Reset
REQ-029 While rst is high: FSM = IDLE; last_grant = 1, so requester 0 wins the first tie; stall counter = 0; wr_en, wr_sel, wr_addr, wr_data, lock_err = 0.
REQ-030 Reset asserted mid-lock SHALL abandon the lock immediately, with no lock_err pulse.
REQ-031 ready outputs SHALL be 0 while rst is high.

Verification
REQ-032 After reset, both valid, addr0=3/data0=0xA, addr1=4/data1=0xB, held 2 cycles -> req0 granted first, then req1; wr_en=1 on both following cycles, wr_sel 0 then 1, wr_addr 3 then 4.
REQ-033 Only req1_valid, addr=0, data=0xFFFF_FFFF -> req1_ready=1; next cycle wr_en=0, wr_sel=1.
REQ-034 req1 beat with lock=1, then req1 idle 3 cycles, then beat with lock=0; req0 valid throughout -> req0_ready=0 through the second req1 beat, then req0 granted.
REQ-035 req0 beat with lock=1, then req0_valid=0 -> lock_err pulses exactly LOCK_MAX cycles later; req1 granted the following cycle.
REQ-036 rst pulsed while in LOCK1 -> FSM returns to IDLE, all outputs 0, lock_err stays 0; a tie after release grants req0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester register-file writeback arbiter.
//   Requester 0 is the ALU writeback, requester 1 the multi-cycle unit.
//   Ties in IDLE are broken round-robin against last_grant.
//   A beat with lock set holds the grant for that requester until a
//   beat without lock, or until LOCK_MAX stall cycles force a release.
// Ports:
//   clk, rst                        clock, async active-high reset
//   reqN_valid/addr/data/lock       write request from requester N
//   reqN_ready                      combinational grant (accept = valid & ready)
//   wr_en/wr_sel/wr_addr/wr_data    registered register-file write port
//   lock_err                        one-cycle pulse on a forced lock release
module rf_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LOCK_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_lock,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              lock_err
);

  localparam int CNT_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  stall_cnt, stall_cnt_nxt;
  logic              gnt0, gnt1, acc, acc_idx, lock_req, force_rel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    stall_cnt_nxt  = stall_cnt;
    force_rel      = 1'b0;

    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          // Round-robin: the side that did not win last time goes now.
          gnt0 = last_grant;
          gnt1 = ~last_grant;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
      end
      // Locked: the other side stays blocked even while the owner idles.
      LOCK0:   gnt0 = req0_valid;
      LOCK1:   gnt1 = req1_valid;
      default: state_nxt = IDLE;
    endcase

    acc      = gnt0 | gnt1;
    acc_idx  = gnt1;
    lock_req = gnt1 ? req1_lock : req0_lock;

    if (acc) begin
      last_grant_nxt = acc_idx;
      stall_cnt_nxt  = '0;
      if (lock_req) state_nxt = acc_idx ? LOCK1 : LOCK0;
      else          state_nxt = IDLE;
    end else if (state == LOCK0 || state == LOCK1) begin
      if (stall_cnt == CNT_MAX) begin
        // Owner stalled too long: drop the lock and flag it.
        force_rel      = 1'b1;
        state_nxt      = IDLE;
        stall_cnt_nxt  = '0;
        last_grant_nxt = (state == LOCK1);
      end else begin
        stall_cnt_nxt = stall_cnt + CNT_W'(1);
      end
    end
  end

  assign sel_addr   = acc_idx ? req1_addr : req0_addr;
  assign sel_data   = acc_idx ? req1_data : req0_data;
  assign req0_ready = gnt0 & ~rst;
  assign req1_ready = gnt1 & ~rst;
  assign lock_err   = force_rel & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      stall_cnt  <= '0;
      wr_en      <= 1'b0;
      wr_sel     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      stall_cnt  <= stall_cnt_nxt;
      if (acc) begin
        // Writes to register 0 are consumed but never reach the file.
        wr_en   <= (sel_addr != '0);
        wr_sel  <= acc_idx;
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: the driver pushes the expected
// write for every beat it expects to be granted; the monitor pops on each
// observed handshake and checks the write port one cycle later.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LM = 15;

  logic          clk = 1'b0, rst = 1'b1;
  logic          v0 = 0, l0 = 0, v1 = 0, l1 = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          r0, r1, wr_en, wr_sel, lock_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_lock(l0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_lock(l1), .req1_ready(r1),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          en;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  logic exp_lock_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus just after the rising edge.
  task automatic drive(input logic iv0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0,
                       input logic il0, input logic iv1, input logic [AW-1:0] ia1,
                       input logic [DW-1:0] id1, input logic il1);
    @(posedge clk); #1;
    v0 = iv0; a0 = ia0; d0 = id0; l0 = il0;
    v1 = iv1; a1 = ia1; d1 = id1; l1 = il1;
  endtask

  // Check the grant for this cycle and queue the resulting write.
  task automatic exp_rdy(input logic e0, input logic e1);
    exp_t e;
    #1;
    chk("req0_ready", {31'b0, r0}, {31'b0, e0});
    chk("req1_ready", {31'b0, r1}, {31'b0, e1});
    if (e0) begin e.sel = 0; e.addr = a0; e.data = d0; e.en = (a0 != 0); sb.push_back(e); end
    if (e1) begin e.sel = 1; e.addr = a1; e.data = d1; e.en = (a1 != 0); sb.push_back(e); end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor
  logic          pend = 0, h_sel = 0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_data = '0;
  exp_t          pe;

  always @(negedge clk) begin
    if (rst) begin
      pend = 0; h_sel = 0; h_addr = '0; h_data = '0;
    end else begin
      if (pend) begin
        chk("wr_en",   {31'b0, wr_en},  {31'b0, pe.en});
        chk("wr_sel",  {31'b0, wr_sel}, {31'b0, pe.sel});
        chk("wr_addr", 32'(wr_addr),    32'(pe.addr));
        chk("wr_data", wr_data,         pe.data);
        h_sel = pe.sel; h_addr = pe.addr; h_data = pe.data;
      end else begin
        chk("wr_en_idle",  {31'b0, wr_en},  32'd0);
        chk("wr_sel_hold", {31'b0, wr_sel}, {31'b0, h_sel});
        chk("wr_addr_hold", 32'(wr_addr),   32'(h_addr));
        chk("wr_data_hold", wr_data,        h_data);
      end
      chk("lock_err", {31'b0, lock_err}, {31'b0, exp_lock_err});
      chk("one_hot_ready", {31'b0, r0 & r1}, 32'd0);
      chk("ready_wo_valid", {30'b0, r1 & ~v1, r0 & ~v0}, 32'd0);
      pend = 0;
      if ((r0 & v0) | (r1 & v1)) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got accept on req%0d expected none", r1);
        end else begin
          pe = sb.pop_front();
          chk("grant_idx", {31'b0, r1}, {31'b0, pe.sel});
          pend = 1;
        end
      end
    end
  end

  initial begin
    // Reset state: ready gated off even with both valids high.
    v0 = 1; v1 = 1;
    #2;
    chk("rst_ready0", {31'b0, r0}, 32'd0);
    chk("rst_ready1", {31'b0, r1}, 32'd0);
    chk("rst_wr", {wr_en, wr_sel, lock_err, 29'(wr_addr)}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    v0 = 0; v1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Tie after reset: req0 first, then req1.
    drive(1, 3, 32'hA, 0, 1, 4, 32'hB, 0); exp_rdy(1, 0);
    drive(1, 3, 32'hA, 0, 1, 4, 32'hB, 0); exp_rdy(0, 1);

    // Write to r0: accepted, suppressed; then outputs hold.
    drive(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0); exp_rdy(0, 1);
    idle(); exp_rdy(0, 0);
    idle(); exp_rdy(0, 0);

    // req1 atomic pair blocks req0 while req1 idles.
    drive(1, 7, 32'h70, 0, 0, 0, 0, 0);     exp_rdy(1, 0);
    drive(1, 7, 32'h70, 0, 1, 9, 32'h90, 1); exp_rdy(0, 1);
    repeat (3) begin
      drive(1, 7, 32'h70, 0, 0, 0, 0, 0);   exp_rdy(0, 0);
    end
    drive(1, 7, 32'h70, 0, 1, 10, 32'hA0, 0); exp_rdy(0, 1);
    drive(1, 7, 32'h70, 0, 0, 0, 0, 0);     exp_rdy(1, 0);
    idle(); exp_rdy(0, 0);

    // req0 locks then vanishes: forced release after LOCK_MAX stalls.
    drive(1, 5, 32'h55, 1, 0, 0, 0, 0); exp_rdy(1, 0);
    for (int k = 1; k <= LM + 1; k++) begin
      drive(0, 0, 0, 0, 1, 6, 32'h66, 0);
      exp_lock_err = (k == LM + 1);
      exp_rdy(0, 0);
    end
    drive(0, 0, 0, 0, 1, 6, 32'h66, 0);
    exp_lock_err = 0;
    exp_rdy(0, 1);

    // Reset in the middle of a req1 lock.
    drive(0, 0, 0, 0, 1, 2, 32'h22, 1); exp_rdy(0, 1);
    drive(1, 1, 32'h11, 0, 0, 0, 0, 0); exp_rdy(0, 0);
    @(posedge clk); #1;
    rst = 1; v0 = 1; v1 = 1; a0 = 1; d0 = 32'h11; a1 = 12; d1 = 32'hC;
    #1;
    chk("midlock_rst_rdy", {30'b0, r1, r0}, 32'd0);
    chk("midlock_rst_wr", {wr_en, wr_sel, lock_err, 29'(wr_addr)}, 32'd0);
    chk("midlock_rst_data", wr_data, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midlock_rst_err", {31'b0, lock_err}, 32'd0);
    end
    rst = 0;
    exp_rdy(1, 0);
    drive(1, 1, 32'h11, 0, 1, 12, 32'hC, 0); exp_rdy(0, 1);
    idle(); exp_rdy(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
